tcp_tx_stream_gen: RTL and testbench
====================================

# tcp_tx_stream_gen

Parametrised multi-channel TX traffic generator for the SiTCP-XG data path, and the successor to the single-stream TCP test generator. It emits framed blocks onto the SiTCP-XG TX interface: one header word per block, then payload from a per-channel incrementing or PRBS sequence. Channels are round-robin interleaved per block. Output rate is paced by a credit accumulator, and the block honours TX almost-full backpressure and connection loss.

## Interface
Parameters:
- DATA_W, 64 — TX word width; 64 or 128 only.
- NUM_CH, 4 — logical channels; 1..256.
- CNT_W, 64 — byte-counter width.
- BLK_W, 24 — block-size field width.

Ports:
- CLK156M  in  1  — sole clock.
- RSTn  in  1  — asynchronous, active-low reset.
- ESTABLISHED  in  1  — SiTCP-XG connection up.
- DATA_GEN  in  1  — rising edge starts a run.
- TX_RATE  in  8  — percent of line rate. 0 = no issue; ≥100 = every cycle.
- NUM_OF_DATA  in  CNT_W  — payload bytes per run.
- BLK_SIZE  in  BLK_W  — payload bytes per block. 0 = whole run is one block.
- CH_EN  in  NUM_CH  — enabled channels.
- MODE  in  1  — 0 = incrementing, 1 = PRBS-32.
- SEQ_PATTERN  in  32  — start value / LFSR seed; channel c uses SEQ_PATTERN ^ c.
- INS_ERROR  in  1  — single-cycle error-injection request.
- TX_AFULL  in  1  — SiTCP-XG TX almost full.
- TX_D  out  DATA_W  — TX data.
- TX_B  out  $clog2(DATA_W/8)+1  — valid bytes in TX_D; 0 = no word.
- BUSY  out  1  — run in progress.
- DONE  out  1  — 1-cycle pulse on normal completion.
- ABORT  out  1  — 1-cycle pulse on connection loss mid-run.
- SENT_BYTES  out  CNT_W  — payload bytes sent in the current/last run.

## Operation
- States: IDLE → HDR → DATA → (HDR | FIN) → IDLE.
- Start condition: IDLE, with DATA_GEN rising edge, ESTABLISHED=1 and CH_EN≠0. On start:
  - latch all config inputs;
  - clear accumulator, SENT_BYTES, per-channel block counters;
  - seed per-channel sequence state;
  - select the lowest enabled channel.
- Start with CH_EN=0 or ESTABLISHED=0 is ignored. NUM_OF_DATA=0 → FIN directly.
- Issue slot: a cycle where acc+TX_RATE ≥ 100 and TX_AFULL=0. On a slot, acc ← acc+TX_RATE−100; otherwise acc ← min(acc+TX_RATE, 199). Accumulator is 9 bits.
- HDR: on a slot, emit header and go to DATA.
  - Header bits [63:56] = channel id, [55:32] = channel block counter (wraps at 2^24), [31:0] = payload bytes of this block.
  - Header bytes above bit 63 are zero.
  - TX_B = DATA_W/8. Header bytes are not counted in SENT_BYTES.
- Block length = min(BLK_SIZE, remaining), where remaining = NUM_OF_DATA − SENT_BYTES.
- DATA: each slot emits min(DATA_W/8, block remainder) bytes.
  - At block end: increment the channel's block counter and advance to the next enabled channel (round-robin, wraps).
  - Then go to HDR if remaining > 0, else FIN.
- Payload, per 32-bit lane k (little-endian lanes):
  - Incrementing: lane k = state+k; state += DATA_W/32 per word.
  - PRBS: Galois LFSR, polynomial 0x80200003, stepped once per lane. Lane k = state after k+1 steps.
  - Bytes beyond TX_B are don't-care; state advances per full word.
- Error injection: INS_ERROR latches a flag. The next payload word has bit 0 inverted, then the flag clears. Sequence state is unaffected. A request while IDLE is held until the first payload word.
- Connection loss: ESTABLISHED=0 while BUSY → IDLE next cycle, ABORT pulse, no DONE. SENT_BYTES is held.
- FIN: DONE pulse, go to IDLE.
- DATA_GEN edges while BUSY are ignored.
- Config changes mid-run have no effect.

## Timing
- Reset values: TX_D=0, TX_B=0, BUSY=0, DONE=0, ABORT=0, SENT_BYTES=0, state IDLE, acc=0, error flag 0.
- All outputs are registered.
- TX_AFULL is sampled in cycle N and gates the word on TX_D in cycle N+1.
- Start edge sampled at N → BUSY=1 and state HDR at N+1 → first header on TX_D at N+2, given full rate and no AFULL.
- TX_B=0 and TX_D=0 in every non-issue cycle.
- DONE asserts the cycle after the last word; BUSY drops in the same cycle.
- Reset mid-run: immediate return to reset values; no DONE/ABORT.

## Structure
- Package tcp_test_pkg holds:
  - state enum;
  - RATE_DEN=100;
  - PRBS_POLY=32'h80200003;
  - header field offsets/widths;
  - DATA_W legality check function.
- Sub-module tcp_seq_lane_gen: combinational next-word/next-state for one channel. Inputs: mode, state. Outputs: DATA_W word, new state.
- Top keeps the per-channel state arrays and one lane-gen instance, muxed by the current channel.

## Test plan
- DATA_W=64, NUM_CH=1, TX_RATE=100, NUM_OF_DATA=640, BLK_SIZE=64, MODE=0, SEQ_PATTERN=0x60808040 → 10 blocks of 1 header + 8 words, back-to-back. Payload lanes increment from 0x60808040. DONE one cycle after the 90th word; SENT_BYTES=640.
- Same, TX_RATE=50 → one word every 2nd cycle; 90 words in 180±1 cycles.
- NUM_OF_DATA=100, BLK_SIZE=64 → block 0 header length 64, 8 words. Block 1 header length 36, 5 words, last TX_B=4.
- NUM_CH=4, CH_EN=4'b0101, NUM_OF_DATA=256, BLK_SIZE=64 → headers ch 0,2,0,2 with block counters 0,0,1,1.
- TX_AFULL high for 20 cycles mid-block → TX_B=0 for exactly those cycles (+1 pipeline cycle); payload continuity intact.
- MODE=1 plus INS_ERROR in cycle 5; separately, ESTABLISHED dropped mid-run → exactly one word with bit 0 flipped and PRBS continuing correctly; on drop, ABORT pulse, BUSY=0 next cycle, no DONE.

Source files
------------

// File: rtl/tcp_test_pkg.sv
// Shared types and constants for the SiTCP-XG TX stream generator.
// Header layout, pacing constants and the PRBS-32 step live here.
package tcp_test_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_FIN
  } state_e;

  localparam int RATE_DEN = 100;
  localparam int ACC_MAX  = 2 * RATE_DEN - 1;

  localparam logic [31:0] PRBS_POLY = 32'h8020_0003;

  localparam int HDR_CH_LSB  = 56;
  localparam int HDR_CH_W    = 8;
  localparam int HDR_CNT_LSB = 32;
  localparam int HDR_CNT_W   = 24;
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_W   = 32;

  function automatic bit data_w_ok(input int w);
    return (w == 64) || (w == 128);
  endfunction

  // Galois form: shift right, fold the polynomial in when bit 0 falls out
  function automatic logic [31:0] prbs_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? PRBS_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/tcp_seq_lane_gen.sv
// Next payload word and next sequence state for one channel.
// Lane k carries state+k (incrementing) or the LFSR after k+1 steps.
module tcp_seq_lane_gen
  import tcp_test_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              mode,
  input  logic [31:0]       state,
  output logic [DATA_W-1:0] word,
  output logic [31:0]       state_nxt
);

  localparam int LANES = DATA_W / 32;

  logic [31:0] lfsr;

  always_comb begin
    word = '0;
    lfsr = state;
    for (int k = 0; k < LANES; k++) begin
      lfsr = prbs_step(lfsr);
      word[32*k +: 32] = mode ? lfsr : state + 32'(k);
    end
    state_nxt = mode ? lfsr : state + 32'(LANES);
  end

endmodule

// File: rtl/tcp_tx_stream_gen.sv
// Multi-channel framed TX generator for the SiTCP-XG data path.
// Blocks are round-robin interleaved across channels, credit-paced.
module tcp_tx_stream_gen
  import tcp_test_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 64,
  parameter int BLK_W  = 24
) (
  input  logic                        CLK156M,
  input  logic                        RSTn,
  input  logic                        ESTABLISHED,
  input  logic                        DATA_GEN,
  input  logic [7:0]                  TX_RATE,
  input  logic [CNT_W-1:0]            NUM_OF_DATA,
  input  logic [BLK_W-1:0]            BLK_SIZE,
  input  logic [NUM_CH-1:0]           CH_EN,
  input  logic                        MODE,
  input  logic [31:0]                 SEQ_PATTERN,
  input  logic                        INS_ERROR,
  input  logic                        TX_AFULL,
  output logic [DATA_W-1:0]           TX_D,
  output logic [$clog2(DATA_W/8):0]   TX_B,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        ABORT,
  output logic [CNT_W-1:0]            SENT_BYTES
);

  localparam int NB   = DATA_W / 8;
  localparam int BW   = $clog2(NB) + 1;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (!data_w_ok(DATA_W)) begin : g_bad_w
    $error("tcp_tx_stream_gen: DATA_W must be 64 or 128");
  end

  function automatic logic [CH_W-1:0] first_ch(
    input logic [NUM_CH-1:0] en
  );
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (|(en & (NUM_CH'(1) << i))) r = CH_W'(i);
    return r;
  endfunction

  // Nearest enabled channel after cur, wrapping; cur itself if alone
  function automatic logic [CH_W-1:0] next_ch(
    input logic [CH_W-1:0]   cur,
    input logic [NUM_CH-1:0] en
  );
    logic [CH_W-1:0] r;
    int idx;
    r = cur;
    for (int i = NUM_CH - 1; i >= 1; i--) begin
      idx = int'(cur) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (|(en & (NUM_CH'(1) << idx))) r = CH_W'(idx);
    end
    return r;
  endfunction

  state_e state_q, state_d;

  logic              dgen_q;
  logic [8:0]        acc_q, acc_d;
  logic [7:0]        rate_q, rate_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic [CNT_W-1:0]  brem_q, brem_d;
  logic [BLK_W-1:0]  bsz_q, bsz_d;
  logic [NUM_CH-1:0] chen_q, chen_d;
  logic              mode_q, mode_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [31:0]       seq_q [NUM_CH];
  logic [31:0]       seq_d [NUM_CH];
  logic [23:0]       bcnt_q [NUM_CH];
  logic [23:0]       bcnt_d [NUM_CH];
  logic              err_q, err_d;
  logic [DATA_W-1:0] txd_q, txd_d;
  logic [BW-1:0]     txb_q, txb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  logic              start;
  logic              slot;
  logic [8:0]        acc_sum;
  logic [8:0]        acc_nxt;
  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  bsz_ext;
  logic [CNT_W-1:0]  blen;
  logic [BW-1:0]     nbytes;
  logic [CNT_W-1:0]  nbytes_ext;
  logic [7:0]        ch_id;
  logic [DATA_W-1:0] hdr_word;
  logic [DATA_W-1:0] pay_word;
  logic [DATA_W-1:0] lane_word;
  logic [31:0]       lane_nxt;

  tcp_seq_lane_gen #(
    .DATA_W (DATA_W)
  ) u_lane (
    .mode      (mode_q),
    .state     (seq_q[ch_q]),
    .word      (lane_word),
    .state_nxt (lane_nxt)
  );

  always_comb begin
    start   = DATA_GEN & ~dgen_q;
    acc_sum = acc_q + 9'(rate_q);
    slot    = (acc_sum >= 9'(RATE_DEN)) && !TX_AFULL;
    if (slot)
      acc_nxt = acc_sum - 9'(RATE_DEN);
    else if (acc_sum > 9'(ACC_MAX))
      acc_nxt = 9'(ACC_MAX);
    else
      acc_nxt = acc_sum;
    rem     = num_q - sent_q;
    bsz_ext = CNT_W'(bsz_q);
    blen    = (bsz_q == '0 || bsz_ext > rem) ? rem : bsz_ext;
    nbytes  = (brem_q >= CNT_W'(NB)) ? BW'(NB)
                                     : brem_q[BW-1:0];
    nbytes_ext = CNT_W'(nbytes);
    ch_id = '0;
    ch_id[CH_W-1:0] = ch_q;
    hdr_word = '0;
    hdr_word[HDR_CH_LSB +: HDR_CH_W]   = ch_id;
    hdr_word[HDR_CNT_LSB +: HDR_CNT_W] = bcnt_q[ch_q];
    hdr_word[HDR_LEN_LSB +: HDR_LEN_W] = HDR_LEN_W'(blen);
    // Injected error only touches the wire, never the sequence state
    pay_word = lane_word ^ DATA_W'(err_q);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rate_d  = rate_q;
    num_d   = num_q;
    bsz_d   = bsz_q;
    chen_d  = chen_q;
    mode_d  = mode_q;
    ch_d    = ch_q;
    sent_d  = sent_q;
    brem_d  = brem_q;
    seq_d   = seq_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q | INS_ERROR;
    txd_d   = '0;
    txb_d   = '0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    if (state_q != S_IDLE && !ESTABLISHED) begin
      state_d = S_IDLE;
      abort_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && ESTABLISHED && CH_EN != '0) begin
            rate_d = (TX_RATE >= 8'(RATE_DEN)) ? 8'(RATE_DEN)
                                               : TX_RATE;
            num_d  = NUM_OF_DATA;
            bsz_d  = BLK_SIZE;
            chen_d = CH_EN;
            mode_d = MODE;
            acc_d  = '0;
            sent_d = '0;
            ch_d   = first_ch(CH_EN);
            for (int i = 0; i < NUM_CH; i++) begin
              seq_d[i]  = SEQ_PATTERN ^ 32'(i);
              bcnt_d[i] = '0;
            end
            state_d = (NUM_OF_DATA == '0) ? S_FIN : S_HDR;
          end
        end
        S_HDR: begin
          acc_d = acc_nxt;
          if (slot) begin
            txd_d   = hdr_word;
            txb_d   = BW'(NB);
            brem_d  = blen;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          acc_d = acc_nxt;
          if (slot) begin
            txd_d = pay_word;
            txb_d = nbytes;
            sent_d = sent_q + nbytes_ext;
            brem_d = brem_q - nbytes_ext;
            seq_d[ch_q] = lane_nxt;
            if (err_q) err_d = INS_ERROR;
            if (brem_q == nbytes_ext) begin
              bcnt_d[ch_q] = bcnt_q[ch_q] + 24'd1;
              ch_d = next_ch(ch_q, chen_q);
              state_d = (rem > nbytes_ext) ? S_HDR : S_FIN;
            end
          end
        end
        S_FIN: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK156M or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      dgen_q  <= 1'b0;
      acc_q   <= '0;
      rate_q  <= '0;
      num_q   <= '0;
      sent_q  <= '0;
      brem_q  <= '0;
      bsz_q   <= '0;
      chen_q  <= '0;
      mode_q  <= 1'b0;
      ch_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        seq_q[i]  <= '0;
        bcnt_q[i] <= '0;
      end
      err_q   <= 1'b0;
      txd_q   <= '0;
      txb_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dgen_q  <= DATA_GEN;
      acc_q   <= acc_d;
      rate_q  <= rate_d;
      num_q   <= num_d;
      sent_q  <= sent_d;
      brem_q  <= brem_d;
      bsz_q   <= bsz_d;
      chen_q  <= chen_d;
      mode_q  <= mode_d;
      ch_q    <= ch_d;
      seq_q   <= seq_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
      txd_q   <= txd_d;
      txb_q   <= txb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign TX_D       = txd_q;
  assign TX_B       = txb_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ABORT      = abort_q;
  assign SENT_BYTES = sent_q;

endmodule

// File: tb/tb_tcp_tx_stream_gen.sv
// Scoreboard bench for tcp_tx_stream_gen (64-bit, 4 channels).
// Expected words are queued per run and popped as TX_B reports words.
module tb_tcp_tx_stream_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        est;
  logic        dgen;
  logic [7:0]  rate;
  logic [63:0] num;
  logic [23:0] bsz;
  logic [3:0]  chen;
  logic        mode;
  logic [31:0] pat;
  logic        ins;
  logic        afull;
  logic [63:0] txd;
  logic [3:0]  txb;
  logic        busy;
  logic        done;
  logic        abort;
  logic [63:0] sent;

  always #5 clk = ~clk;

  tcp_tx_stream_gen #(
    .DATA_W (64),
    .NUM_CH (4),
    .CNT_W  (64),
    .BLK_W  (24)
  ) dut (
    .CLK156M     (clk),
    .RSTn        (rst_n),
    .ESTABLISHED (est),
    .DATA_GEN    (dgen),
    .TX_RATE     (rate),
    .NUM_OF_DATA (num),
    .BLK_SIZE    (bsz),
    .CH_EN       (chen),
    .MODE        (mode),
    .SEQ_PATTERN (pat),
    .INS_ERROR   (ins),
    .TX_AFULL    (afull),
    .TX_D        (txd),
    .TX_B        (txb),
    .BUSY        (busy),
    .DONE        (done),
    .ABORT       (abort),
    .SENT_BYTES  (sent)
  );

  typedef struct {
    logic [3:0]  b;
    logic [63:0] d;
    bit          hdr;
  } exp_t;

  exp_t   sbq[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     nwords = 0;
  int     first_cyc = -1;
  int     last_cyc = 0;
  int     done_cnt = 0;
  int     done_cyc = 0;
  int     abort_cnt = 0;
  logic   busy_at_done = 1'b0;
  longint pay_bytes = 0;
  int     c0 = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr(input logic [31:0] x);
    logic lsb;
    lsb = x[0];
    x = x >> 1;
    if (lsb) x = x ^ 32'h8020_0003;
    return x;
  endfunction

  task automatic push_run(input longint n, input int bs,
                          input logic [3:0] en, input bit md,
                          input logic [31:0] seed,
                          input int f0, input int f1);
    logic [31:0] sq[4];
    int cnt[4];
    int ch;
    int pi;
    longint snt, blen, r;
    logic [31:0] lo, hi;
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      sq[c] = seed ^ 32'(c);
      cnt[c] = 0;
    end
    ch = 0;
    while (!en[ch]) ch++;
    snt = 0;
    pi = 0;
    while (snt < n) begin
      blen = (bs == 0 || bs > n - snt) ? n - snt : longint'(bs);
      e.hdr = 1'b1;
      e.b = 4'd8;
      e.d = {8'(ch), 24'(cnt[ch]), 32'(blen)};
      sbq.push_back(e);
      r = blen;
      while (r > 0) begin
        e.hdr = 1'b0;
        e.b = (r >= 8) ? 4'd8 : 4'(r);
        if (md) begin
          lo = lfsr(sq[ch]);
          hi = lfsr(lo);
          sq[ch] = hi;
        end else begin
          lo = sq[ch];
          hi = sq[ch] + 32'd1;
          sq[ch] = sq[ch] + 32'd2;
        end
        e.d = {hi, lo};
        if (pi == f0 || pi == f1) e.d[0] = ~e.d[0];
        pi++;
        sbq.push_back(e);
        r = r - longint'(e.b);
        snt = snt + longint'(e.b);
      end
      cnt[ch]++;
      do ch = (ch + 1) % 4; while (!en[ch]);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t e;
    logic [63:0] m;
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      if (abort) abort_cnt++;
      if (txb != 4'd0) begin
        if (sbq.size() == 0) begin
          check("extra_word", 64'(txb), 64'd0);
        end else begin
          e = sbq.pop_front();
          m = (e.b >= 4'd8) ? '1 : ((64'd1 << (8 * e.b)) - 64'd1);
          check(e.hdr ? "hdr" : "payload", txd & m, e.d & m);
          check("txb", 64'(txb), 64'(e.b));
          if (!e.hdr) pay_bytes += longint'(txb);
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        nwords++;
      end else begin
        check("idle_txd", txd, 64'd0);
      end
    end
  end

  task automatic start_run(input logic [7:0] r, input longint n,
                           input int bs, input logic [3:0] en,
                           input bit md, input logic [31:0] p);
    @(negedge clk);
    rate = r;
    num = n;
    bsz = 24'(bs);
    chen = en;
    mode = md;
    pat = p;
    nwords = 0;
    pay_bytes = 0;
    first_cyc = -1;
    c0 = cyc;
    dgen = 1'b1;
    @(negedge clk);
    dgen = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n;
    int d0;
    n = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < lim), 64'd1);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int d0;
    int a0;
    rst_n = 1'b0;
    est = 1'b1;
    dgen = 1'b0;
    rate = 8'd100;
    num = '0;
    bsz = '0;
    chen = '0;
    mode = 1'b0;
    pat = '0;
    ins = 1'b0;
    afull = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txb", 64'(txb), 64'd0);
    check("rst_txd", txd, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_abort", 64'(abort), 64'd0);
    check("rst_sent", sent, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full rate, one channel, 10 blocks back to back
    push_run(640, 64, 4'b0001, 1'b0, 32'h6080_8040, -1, -1);
    start_run(8'd100, 640, 64, 4'b0001, 1'b0, 32'h6080_8040);
    wait_done("t1_timeout", 400);
    check("t1_words", 64'(nwords), 64'd90);
    check("t1_latency", 64'(first_cyc - c0), 64'd2);
    check("t1_span", 64'(last_cyc - first_cyc), 64'd89);
    check("t1_done_cyc", 64'(done_cyc - last_cyc), 64'd1);
    check("t1_busy_at_done", 64'(busy_at_done), 64'd0);
    check("t1_sent", sent, 64'd640);
    check("t1_queue", 64'(sbq.size()), 64'd0);
    repeat (3) @(negedge clk);

    // half rate
    push_run(640, 64, 4'b0001, 1'b0, 32'h6080_8040, -1, -1);
    start_run(8'd50, 640, 64, 4'b0001, 1'b0, 32'h6080_8040);
    wait_done("t2_timeout", 600);
    check("t2_words", 64'(nwords), 64'd90);
    check("t2_span", 64'(last_cyc - first_cyc), 64'd178);
    check("t2_sent", sent, 64'd640);
    repeat (3) @(negedge clk);

    // short tail block
    push_run(100, 64, 4'b0001, 1'b0, 32'hA5A5_0000, -1, -1);
    start_run(8'd100, 100, 64, 4'b0001, 1'b0, 32'hA5A5_0000);
    wait_done("t3_timeout", 200);
    check("t3_words", 64'(nwords), 64'd15);
    check("t3_sent", sent, 64'd100);
    check("t3_queue", 64'(sbq.size()), 64'd0);
    repeat (3) @(negedge clk);

    // two of four channels interleaved
    push_run(256, 64, 4'b0101, 1'b0, 32'h1122_3344, -1, -1);
    start_run(8'd100, 256, 64, 4'b0101, 1'b0, 32'h1122_3344);
    wait_done("t4_timeout", 200);
    check("t4_words", 64'(nwords), 64'd36);
    check("t4_queue", 64'(sbq.size()), 64'd0);
    repeat (3) @(negedge clk);

    // backpressure for 20 cycles mid-run
    push_run(640, 64, 4'b0001, 1'b0, 32'h0000_1000, -1, -1);
    start_run(8'd100, 640, 64, 4'b0001, 1'b0, 32'h0000_1000);
    repeat (10) @(negedge clk);
    afull = 1'b1;
    repeat (20) @(negedge clk);
    afull = 1'b0;
    wait_done("t5_timeout", 400);
    check("t5_words", 64'(nwords), 64'd90);
    check("t5_span", 64'(last_cyc - first_cyc), 64'd109);
    check("t5_queue", 64'(sbq.size()), 64'd0);
    repeat (3) @(negedge clk);

    // PRBS with one request held from idle and one mid-block
    push_run(640, 64, 4'b0001, 1'b1, 32'hDEAD_BEEF, 0, 4);
    @(negedge clk);
    ins = 1'b1;
    @(negedge clk);
    ins = 1'b0;
    start_run(8'd100, 640, 64, 4'b0001, 1'b1, 32'hDEAD_BEEF);
    repeat (4) @(negedge clk);
    ins = 1'b1;
    @(negedge clk);
    ins = 1'b0;
    wait_done("t6_timeout", 400);
    check("t6_words", 64'(nwords), 64'd90);
    check("t6_queue", 64'(sbq.size()), 64'd0);
    repeat (3) @(negedge clk);

    // connection loss mid-run
    push_run(640, 64, 4'b0001, 1'b0, 32'h0BAD_F00D, -1, -1);
    d0 = done_cnt;
    a0 = abort_cnt;
    start_run(8'd100, 640, 64, 4'b0001, 1'b0, 32'h0BAD_F00D);
    repeat (30) @(negedge clk);
    est = 1'b0;
    @(negedge clk);
    check("ab_pulse", 64'(abort), 64'd1);
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_txb", 64'(txb), 64'd0);
    check("ab_words", 64'(nwords), 64'd30);
    check("ab_sent", sent, 64'd208);
    check("ab_sent_vs_seen", sent, 64'(pay_bytes));
    @(negedge clk);
    check("ab_pulse_end", 64'(abort), 64'd0);
    sbq.delete();
    est = 1'b1;
    repeat (5) @(negedge clk);
    check("ab_no_done", 64'(done_cnt - d0), 64'd0);
    check("ab_count", 64'(abort_cnt - a0), 64'd1);
    check("ab_sent_held", sent, 64'd208);

    // starts that must be ignored
    start_run(8'd100, 64, 64, 4'b0000, 1'b0, 32'h0);
    repeat (5) @(negedge clk);
    check("no_ch_busy", 64'(busy), 64'd0);
    check("no_ch_words", 64'(nwords), 64'd0);
    est = 1'b0;
    start_run(8'd100, 64, 64, 4'b0001, 1'b0, 32'h0);
    repeat (5) @(negedge clk);
    check("no_est_busy", 64'(busy), 64'd0);
    check("no_est_words", 64'(nwords), 64'd0);
    est = 1'b1;
    repeat (2) @(negedge clk);

    // empty run goes straight to completion
    start_run(8'd100, 0, 64, 4'b0001, 1'b0, 32'h0);
    wait_done("t8_timeout", 50);
    check("t8_words", 64'(nwords), 64'd0);
    check("t8_done_cyc", 64'(done_cyc - c0), 64'd2);
    check("t8_sent", sent, 64'd0);
    repeat (3) @(negedge clk);

    // reset in the middle of a run
    push_run(640, 64, 4'b0001, 1'b0, 32'h0, -1, -1);
    d0 = done_cnt;
    start_run(8'd100, 640, 64, 4'b0001, 1'b0, 32'h0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_txb", 64'(txb), 64'd0);
    check("mrst_sent", sent, 64'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mrst_no_done", 64'(done_cnt - d0), 64'd0);
    check("mrst_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
